round_scheduler: RTL

ROUND_SCHEDULER -- requirements
Module: round_scheduler

---
 rtl/round_scheduler.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/round_scheduler.sv
// -----------------------------------------------------------------------------
// round_scheduler
//
// Sequences a multi-round permutation job across five step units
// (theta, rho, pi, chi, iota). Each round launches every step in order.
// Each step gets a one-cycle start pulse, and the next step is not launched
// until the current unit reports completion. The shared lane-memory port is
// handed to whichever step is active.
//
// Moore FSM: Idle -> Launch -> Wait -> Advance -> (Launch | Finish) -> Idle.
// All outputs are decoded from registered state and counters only.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   job request, accepted only in Idle
//   stepDone   in   per-step completion, bit i from step unit i
//   stepStart  out  one-hot launch pulse to step unit i
//   memSel     out  lane-memory port owner (step index), 0 when idle
//   round      out  current round index
//   busy       out  high in every state except Idle
//   done       out  one-cycle job-complete pulse
//   err        out  sticky watchdog flag
//
// Optional feature macro: STEP_TIMEOUT_EN
//   Defined:   an 8-bit watchdog aborts a step after TIMEOUT Wait cycles
//              without completion. It returns to Idle and sets err.
//   Undefined: no watchdog exists, err is tied low, Wait waits indefinitely.
// -----------------------------------------------------------------------------
module round_scheduler #(
  parameter int ROUNDS  = 24,  // rounds per job, 1..31
  parameter int STEPS   = 5,   // step units per round, fixed at 5
  parameter int TIMEOUT = 64   // watchdog limit in Wait cycles, 1..255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [STEPS-1:0] stepDone,
  output logic [STEPS-1:0] stepStart,
  output logic [2:0]       memSel,
  output logic [4:0]       round,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_ADVANCE,
    S_FINISH
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [4:0] round_q, round_d;
  logic       step_hit;

  // Only the active step's completion bit matters. Every other bit is ignored.
  assign step_hit = stepDone[step_q];

`ifdef STEP_TIMEOUT_EN
  logic [7:0] wd_q, wd_d;
  logic       err_q, err_d;
  logic       wd_expired;

  assign wd_expired = (wd_q == 8'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^8'(TIMEOUT);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      state_q <= S_IDLE;
      step_q  <= '0;
      round_q <= '0;
`ifdef STEP_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      round_q <= round_d;
`ifdef STEP_TIMEOUT_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next-state and counter logic
  always_comb begin
    // NOTE: hold-value defaults up front keep every path assigned. Without
    // them this block would infer latches.
    state_d = state_q;
    step_d  = step_q;
    round_d = round_q;
`ifdef STEP_TIMEOUT_EN
    wd_d    = wd_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LAUNCH;
          step_d  = '0;
          round_d = '0;
`ifdef STEP_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
`ifdef STEP_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      S_WAIT: begin
        // Completion is tested first, so a same-cycle done beats the timeout.
        if (step_hit) begin
          state_d = S_ADVANCE;
`ifdef STEP_TIMEOUT_EN
        end else if (wd_expired) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          wd_d    = wd_q + 8'd1;
`endif
        end
      end
      S_ADVANCE: begin
        if (step_q != 3'(STEPS - 1)) begin
          step_d  = step_q + 3'd1;
          state_d = S_LAUNCH;
        end else if (round_q != 5'(ROUNDS - 1)) begin
          round_d = round_q + 5'd1;
          step_d  = '0;
          state_d = S_LAUNCH;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    stepStart = '0;
    memSel    = '0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE:    busy = 1'b0;
      S_LAUNCH: begin
        stepStart[step_q] = 1'b1;
        memSel            = step_q;
      end
      S_WAIT:    memSel = step_q;
      S_ADVANCE: memSel = step_q;
      S_FINISH:  done   = 1'b1;
      default:   busy   = 1'b0;
    endcase
  end

  // The round index is held after Finish until the next accepted start.
  assign round = round_q;

`ifdef STEP_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
